// File: rtl/instr_issue_queue.sv
// Packs field-level instruction requests into 32-bit IR words and queues them for issue to the core.
// Optional build macro FIELD_CHECK_EN rejects requests whose oper_type exceeds MAX_OPER.
module instr_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int MAX_OPER = 11
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_oper_type,
    input  logic                       req_imm_mode,
    input  logic [4:0]                 req_rdst,
    input  logic [4:0]                 req_rsrc1,
    input  logic [4:0]                 req_rsrc2,
    input  logic [15:0]                req_isrc,
    input  logic                       flush,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_ir,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       req_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          req_err_q, req_err_d;

    logic          full;
    logic          empty;
    logic          req_fire;
    logic          oper_bad;
    logic          push_en;
    logic          pop_en;
    logic [31:0]   packed_word;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign req_ready   = !full && !flush;
    assign issue_valid = !empty;
    assign issue_ir    = empty ? 32'h0 : mem_q[rptr_q[AW-1:0]];
    assign count       = count_q;
    assign req_err     = req_err_q;

    assign req_fire = req_valid && req_ready;

`ifdef FIELD_CHECK_EN
    localparam logic [4:0] MAX_OPER_V = 5'(MAX_OPER);
    assign oper_bad = (req_oper_type > MAX_OPER_V);
`else
    assign oper_bad = 1'b0;
`endif

    assign push_en = req_fire && !oper_bad;
    assign pop_en  = issue_valid && issue_ready && !flush;

    // Immediate form places isrc in the low half; register form puts rsrc2 on top of a zero tail.
    always_comb begin
        packed_word = {req_oper_type, req_rdst, req_rsrc1, req_imm_mode, 16'h0};
        if (req_imm_mode) begin
            packed_word[15:0] = req_isrc;
        end else begin
            packed_word[15:0] = {req_rsrc2, 11'h0};
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        req_err_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_en) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            req_err_d = req_fire && oper_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            req_err_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            req_err_q <= req_err_d;
        end
    end

    // Storage is deliberately left uncleared by reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (sys_rst_n && push_en && !flush) begin
            mem_q[wptr_q[AW-1:0]] <= packed_word;
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: stimulus queues expected IR words, a negedge monitor checks issues.
// Honors FIELD_CHECK_EN to pick the expected handling of out-of-range oper_type.
module tb_instr_issue_queue;

    logic        clk;
    logic        sys_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_oper_type;
    logic        req_imm_mode;
    logic [4:0]  req_rdst;
    logic [4:0]  req_rsrc1;
    logic [4:0]  req_rsrc2;
    logic [15:0] req_isrc;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_ir;
    logic [2:0]  count;
    logic        req_err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];

    instr_issue_queue #(.DEPTH(4), .MAX_OPER(11)) dut (
        .clk(clk),
        .sys_rst_n(sys_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_oper_type(req_oper_type),
        .req_imm_mode(req_imm_mode),
        .req_rdst(req_rdst),
        .req_rsrc1(req_rsrc1),
        .req_rsrc2(req_rsrc2),
        .req_isrc(req_isrc),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_ir(issue_ir),
        .count(count),
        .req_err(req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-form words for the wrap-around run: oper 4, rdst=rsrc1=rsrc2=j.
    logic [31:0] wrap_words [10] = '{
        32'h20420800, 32'h20841000, 32'h20C61800, 32'h21082000, 32'h214A2800,
        32'h218C3000, 32'h21CE3800, 32'h22104000, 32'h22524800, 32'h22945000
    };
    // Immediate-form words for fill/flush: oper 3, rdst=k, isrc=0xA0+k.
    logic [31:0] fill_words [5] = '{
        32'h184100A1, 32'h188100A2, 32'h18C100A3, 32'h190100A4, 32'h194100A5
    };

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and hold it until the queue takes it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [4:0] op, input logic imm, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] isrc,
                                 input logic [31:0] exp_word, input bit queued, input int exp_count);
        bit accepted = 0;
        req_oper_type = op;
        req_imm_mode  = imm;
        req_rdst      = rd;
        req_rsrc1     = rs1;
        req_rsrc2     = rs2;
        req_isrc      = isrc;
        req_valid     = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (c == 0 && exp_count >= 0) checkOutput("count_before_push", 32'(count), 32'(exp_count));
            if (req_ready) begin
                if (queued) sb.push_back(exp_word);
                tick();
                accepted = 1;
            end
        end
        if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        issue_ready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (count == 3'd0) done = 1;
        end
        issue_ready = 1'b0;
        checkOutput("drain_count", 32'(count), 32'd0);
        checkOutput("empty_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("empty_issue_ir", issue_ir, 32'h0);
    endtask

    // Monitor: every issue handshake must deliver the oldest outstanding expected word.
    always @(negedge clk) begin
        if (sys_rst_n === 1'b1 && flush === 1'b0 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", issue_ir, 32'hxxxxxxxx);
            end else begin
                checkOutput("issue_ir", issue_ir, sb.pop_front());
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        sys_rst_n = 1'b0;
        req_valid = 1'b0;
        req_oper_type = '0;
        req_imm_mode = 1'b0;
        req_rdst = '0;
        req_rsrc1 = '0;
        req_rsrc2 = '0;
        req_isrc = '0;
        flush = 1'b0;
        issue_ready = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("rst_issue_ir", issue_ir, 32'h0);
        checkOutput("rst_req_err", 32'(req_err), 32'd0);
        tick();

        $display("[TB] ADI into empty queue");
        applyStimulus(5'd2, 1'b1, 5'd0, 5'd2, 5'd0, 16'd4, 32'h10050004, 1, 0);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("adi_issue_valid", 32'(issue_valid), 32'd1);
        checkOutput("adi_issue_ir", issue_ir, 32'h10050004);
        checkOutput("adi_count", 32'(count), 32'd1);
        tick();
        drain();
        tick();

        $display("[TB] ADD then MOVI back-to-back");
        issue_ready = 1'b1;
        applyStimulus(5'd2, 1'b0, 5'd0, 5'd4, 5'd5, 16'hFFFF, 32'h10082800, 1, -1);
        applyStimulus(5'd1, 1'b1, 5'd4, 5'd0, 5'd31, 16'd55, 32'h09010037, 1, -1);
        req_valid = 1'b0;
        drain();
        tick();

        $display("[TB] Fill to DEPTH and hold the fifth request");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'd3, 1'b1, 5'(k + 1), 5'd0, 5'd31, 16'(16'hA1 + k), fill_words[k], 1, k);
        end
        req_rdst = 5'd5;
        req_isrc = 16'hA5;
        @(negedge clk);
        checkOutput("full_req_ready", 32'(req_ready), 32'd0);
        checkOutput("full_count", 32'(count), 32'd4);
        tick();
        issue_ready = 1'b1;
        @(negedge clk);
        checkOutput("full_pop_req_ready", 32'(req_ready), 32'd0);
        tick();
        issue_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_pop_count", 32'(count), 32'd3);
        checkOutput("after_pop_req_ready", 32'(req_ready), 32'd1);
        sb.push_back(fill_words[4]);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("refill_count", 32'(count), 32'd4);
        tick();
        drain();
        tick();

        $display("[TB] Wrap-around with overlapped push/pop");
        for (int j = 0; j < 10; j++) begin
            if (j == 2) issue_ready = 1'b1;
            applyStimulus(5'd4, 1'b0, 5'(j + 1), 5'(j + 1), 5'(j + 1), 16'hFFFF, wrap_words[j], 1,
                          (j < 2) ? j : 2);
        end
        req_valid = 1'b0;
        issue_ready = 1'b0;
        @(negedge clk);
        checkOutput("wrap_tail_count", 32'(count), 32'd2);
        tick();
        drain();
        tick();

        $display("[TB] Flush with count=3 and a pending request");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(5'd3, 1'b1, 5'(k + 1), 5'd0, 5'd31, 16'(16'hA1 + k), fill_words[k], 1, k);
        end
        req_rdst = 5'd4;
        req_isrc = 16'hA4;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("flush_issue_ir", issue_ir, 32'h0);
        tick();

        $display("[TB] Reset mid-stream");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(5'd3, 1'b1, 5'(k + 1), 5'd0, 5'd31, 16'(16'hA1 + k), fill_words[k], 1, k);
        end
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        tick();

        $display("[TB] oper_type above MAX_OPER");
`ifdef FIELD_CHECK_EN
        applyStimulus(5'd12, 1'b1, 5'd1, 5'd1, 5'd0, 16'h1234, 32'h60431234, 0, 0);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("fc_req_err", 32'(req_err), 32'd1);
        checkOutput("fc_count", 32'(count), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("fc_req_err_clear", 32'(req_err), 32'd0);
        tick();
`else
        applyStimulus(5'd12, 1'b1, 5'd1, 5'd1, 5'd0, 16'h1234, 32'h60431234, 1, 0);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("fc_req_err", 32'(req_err), 32'd0);
        checkOutput("fc_count", 32'(count), 32'd1);
        tick();
`endif
        drain();
        tick();

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
